// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters sharing the 8x3 encoder datapath.
// Grants are registered, held until release, request drop or hold-timer expiry.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       release_pulse,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int HW = ($clog2(MAX_HOLD + 1) > 4) ? $clog2(MAX_HOLD + 1) : 4;
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_SAT   = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [2:0]    ptr, ptr_next;
    logic [2:0]    owner, owner_next;
    logic [HW-1:0] hold_cnt, hold_cnt_next;
    logic [7:0]    grant_next;
    logic [2:0]    grant_idx_next;
    logic          grant_valid_next;
    logic          timeout_next;
    logic [2:0]    pick;
    logic          rel_exit;
    logic          tmo_hit;

    // First set request bit searching circularly upward from p.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] sel;
        logic       found;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = p + 3'(i);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(req, ptr);

    always_comb begin
        state_next       = state;
        ptr_next         = ptr;
        owner_next       = owner;
        hold_cnt_next    = hold_cnt;
        grant_next       = grant;
        grant_idx_next   = grant_idx;
        grant_valid_next = grant_valid;
        timeout_next     = 1'b0;
        rel_exit         = release_pulse | ~req[owner];
        tmo_hit          = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT);
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next       = GRANT;
                    owner_next       = pick;
                    grant_next       = 8'b1 << pick;
                    grant_idx_next   = pick;
                    grant_valid_next = 1'b1;
                    hold_cnt_next    = HW'(1);
                end
            end
            GRANT: begin
                if (rel_exit || tmo_hit) begin
                    state_next       = IDLE;
                    ptr_next         = owner + 3'd1;
                    grant_next       = 8'b0;
                    grant_idx_next   = 3'b0;
                    grant_valid_next = 1'b0;
                    hold_cnt_next    = '0;
                    // A normal exit coinciding with expiry is not reported as a timeout.
                    timeout_next     = tmo_hit & ~rel_exit;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_cnt_next = hold_cnt + HW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'b0;
            owner       <= 3'b0;
            hold_cnt    <= '0;
            grant       <= 8'b0;
            grant_idx   <= 3'b0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            owner       <= owner_next;
            hold_cnt    <= hold_cnt_next;
            grant       <= grant_next;
            grant_idx   <= grant_idx_next;
            grant_valid <= grant_valid_next;
            timeout     <= timeout_next;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8 (MAX_HOLD=4): directed scenarios plus random traffic
// checked against a transaction-level arbitration model.
module tb_rr_arbiter_8;

    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int total;
    int bad;

    // reference model state
    bit m_busy;
    int m_owner;
    int m_held;
    int m_ptr;
    bit m_tmo;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .release_pulse(rel),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_held  = 0;
        m_ptr   = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rl);
        bit by_req;
        bit by_time;
        if (!m_busy) begin
            m_tmo = 1'b0;
            if (r != 8'b0) begin
                for (int k = 0; k < 8; k++) begin
                    if (!m_busy && r[(m_ptr + k) % 8]) begin
                        m_owner = (m_ptr + k) % 8;
                        m_busy  = 1'b1;
                        m_held  = 1;
                    end
                end
            end
        end else begin
            by_req  = rl || !r[m_owner];
            by_time = (MH != 0) && (m_held == MH);
            if (by_req || by_time) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 8;
                m_tmo  = by_time && !by_req;
            end else begin
                m_held++;
                m_tmo = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step(req, rel);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'b0;
        rel = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        rel = 1'b0;
        tick();
        tick();
        total++;
        if ({grant, grant_idx, grant_valid, timeout} !== 13'b0) begin
            bad++;
            $display("FAIL reset_outputs: got grant=%h idx=%0d vld=%b to=%b want all zero",
                     grant, grant_idx, grant_valid, timeout);
        end
        rst = 1'b0;
        req = 8'b0000_0001;
        tick();
        total++;
        if (grant !== 8'b0000_0001 || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_req: got grant=%b idx=%0d vld=%b want 00000001/0/1",
                     grant, grant_idx, grant_valid);
        end
        req = 8'b0;
        tick();
        total++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL single_drop: got vld=%b to=%b want 0/0", grant_valid, timeout);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 8'hFF;
        tick();
        total++;
        if (grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL rr_first: got idx=%0d vld=%b want 0/1", grant_idx, grant_valid);
        end
        for (int k = 1; k <= 8; k++) begin
            rel = 1'b1;
            tick();
            total++;
            if (grant_valid !== 1'b0 || grant !== 8'b0) begin
                bad++;
                $display("FAIL rr_gap%0d: got vld=%b grant=%h want 0/00", k, grant_valid, grant);
            end
            rel = 1'b0;
            tick();
            total++;
            if (grant_idx !== 3'(k % 8) || grant_valid !== 1'b1 || grant !== (8'b1 << (k % 8))) begin
                bad++;
                $display("FAIL rr_grant%0d: got idx=%0d grant=%b want idx=%0d", k, grant_idx, grant, k % 8);
            end
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        req = 8'b0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'b0000_1000;
        for (int c = 1; c <= MH; c++) begin
            tick();
            total++;
            if (grant_idx !== 3'd3 || grant_valid !== 1'b1 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL tmo_hold%0d: got idx=%0d vld=%b to=%b want 3/1/0", c, grant_idx, grant_valid, timeout);
            end
        end
        tick();
        total++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL tmo_pulse: got vld=%b to=%b want 0/1", grant_valid, timeout);
        end
        tick();
        total++;
        if (grant_idx !== 3'd3 || grant_valid !== 1'b1 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL tmo_regrant: got idx=%0d vld=%b to=%b want 3/1/0", grant_idx, grant_valid, timeout);
        end
    endtask

    // Continues from the re-grant left by test_timeout (first grant cycle of owner 3).
    task automatic test_coincide();
        tick();
        tick();
        tick();
        total++;
        if (grant_idx !== 3'd3 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL coin_held: got idx=%0d vld=%b want 3/1", grant_idx, grant_valid);
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        total++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL coin_exit: got vld=%b to=%b want 0/0", grant_valid, timeout);
        end
        req = 8'b0;
        tick();
        total++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL coin_idle: got vld=%b to=%b want 0/0", grant_valid, timeout);
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 8'b0110_0000;
        tick();
        tick();
        total++;
        if (grant_idx !== 3'd5 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL drop_owner: got idx=%0d vld=%b want 5/1", grant_idx, grant_valid);
        end
        req = 8'b0100_0000;
        tick();
        total++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL drop_exit: got vld=%b to=%b want 0/0", grant_valid, timeout);
        end
        tick();
        total++;
        if (grant_idx !== 3'd6 || grant !== 8'b0100_0000) begin
            bad++;
            $display("FAIL drop_next: got idx=%0d grant=%b want 6/01000000", grant_idx, grant);
        end
        req = 8'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 8'b0000_0100;
        tick();
        total++;
        if (grant_idx !== 3'd2 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: got idx=%0d vld=%b want 2/1", grant_idx, grant_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (grant !== 8'b0 || grant_idx !== 3'd0 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: got grant=%h idx=%0d vld=%b want 0/0/0", grant, grant_idx, grant_valid);
        end
        req = 8'b1000_0100;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (grant_idx !== 3'd2 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_after: got idx=%0d vld=%b want 2/1", grant_idx, grant_valid);
        end
        req = 8'b0;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_grant;
        logic [2:0] exp_idx;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req = (n % 50 < 25) ? 8'($urandom) : 8'($urandom) & 8'($urandom);
            rel = ($urandom_range(0, 3) == 0);
            tick();
            exp_grant = m_busy ? (8'b1 << m_owner) : 8'b0;
            exp_idx   = m_busy ? 3'(m_owner) : 3'b0;
            total++;
            if (grant !== exp_grant || grant_idx !== exp_idx || grant_valid !== m_busy || timeout !== m_tmo) begin
                bad++;
                $display("FAIL rand_cycle%0d: got grant=%b idx=%0d vld=%b to=%b want %b/%0d/%b/%b",
                         n, grant, grant_idx, grant_valid, timeout, exp_grant, exp_idx, m_busy, m_tmo);
            end
        end
        rel = 1'b0;
        req = 8'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 8'b0;
        rel   = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_timeout();
        test_coincide();
        test_drop();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that lets eight requesters share the 8x3 encoder datapath. It grants one requester at a time and holds the grant until that requester releases it, drops its request, or a hold timer expires. The grant is presented both one-hot and as a 3-bit encoded index, so the same value can drive the encoder input and a downstream mux. The block sits between the requesting units and the encoder.

## Interface
Parameters:
- MAX_HOLD, 15, maximum number of consecutive cycles a grant may be held before it is forcibly revoked; 0 disables the timer.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request vector; bit i is requester i and stays high while it wants or holds the resource.
- release  in  1  single-cycle pulse from the current owner meaning "done"; ignored when no grant is active.
- grant  out  8  one-hot grant vector; all zeros when idle.
- grant_idx  out  3  binary index of the granted requester; 0 when idle.
- grant_valid  out  1  high whenever grant is non-zero.
- timeout  out  1  one-cycle pulse indicating the previous grant was revoked by the hold timer.

## Operation
- State machine with two states, IDLE and GRANT.
- Internal registers:
  - ptr: 3-bit round-robin pointer.
  - hold_cnt: 4-bit minimum width, must hold MAX_HOLD.
  - owner: 3-bit index of the current grantee.
- **IDLE.** If req is non-zero, select the first set bit searching circularly from ptr upward (ptr, ptr+1, ..., 7, 0, ...). At the next edge:
  - load owner with that index;
  - drive grant=1<<owner, grant_idx=owner, grant_valid=1;
  - set hold_cnt=1;
  - move to GRANT.
  - If req is zero, remain in IDLE.
- **GRANT.** Grant outputs stay constant. Exit to IDLE at the next edge when any of the following holds:
  - (a) release=1;
  - (b) req[owner]=0;
  - (c) MAX_HOLD≠0 and hold_cnt==MAX_HOLD.
  - Otherwise hold_cnt increments by 1 (saturating; it cannot overflow because of (c)).
- **On exit:**
  - ptr <= owner+1 mod 8 (wraps 7→0);
  - grant, grant_idx and grant_valid clear;
  - hold_cnt clears.
- **timeout.** Set to 1 in the IDLE cycle following an exit caused only by (c), and 0 in every other cycle.
- **Priority when exit causes coincide.** (a) or (b) together with (c) counts as a normal exit and produces no timeout pulse.
- **Fairness.** Requests from non-owners that arrive during GRANT are held off; they are evaluated in the mandatory IDLE cycle.
- **Reset.** Asserting rst at any time, including mid-grant, immediately sets:
  - state=IDLE, ptr=0, owner=0, hold_cnt=0;
  - grant=8'b0, grant_idx=3'b0, grant_valid=0, timeout=0.
  - After rst deasserts, the first arbitration starts from requester 0.

## Timing
- All outputs are registered; none is combinational from req or release.
- Request-to-grant latency: if req is non-zero in an IDLE cycle, grant is visible after the next rising edge (1 cycle).
- Release-to-drop latency: a release sampled high at edge k clears grant at edge k, so grant is low in the following cycle.
- Every grant is followed by exactly one IDLE cycle. Back-to-back ownership changes therefore occur every (hold + 1) cycles at minimum, giving 2 cycles per grant when release is pulsed in the first GRANT cycle.
- Maximum hold is MAX_HOLD cycles of grant_valid=1. The timeout pulse occupies the cycle immediately after the last grant cycle.
- Worst-case wait for a continuously requesting input is 7 × (MAX_HOLD + 1) + 1 cycles.

## Test plan
- **Reset and single request.** Assert rst, then deassert; set req=8'b0000_0001 → one edge later grant=8'b0000_0001, grant_idx=3'b000, grant_valid=1; all outputs were 0 during reset.
- **Round robin under full load.** req=8'hFF, pulse release in every GRANT cycle → grant_idx sequence 0,1,2,...,7,0, with grant_valid=0 for one cycle between grants.
- **Timer expiry (MAX_HOLD=4).** req=8'b0000_1000 held, no release → grant_idx=3'b011 for exactly 4 cycles, then one IDLE cycle with timeout=1, then a re-grant to index 3 (ptr=4 wraps around to 3).
- **Release and timeout coincide (MAX_HOLD=4).** release pulsed on the 4th grant cycle → exit with timeout=0.
- **Request drop.** Owner 5 holds the grant with req=8'b0110_0000; req[5] falls → next cycle IDLE, timeout=0; following cycle grant_idx=3'b110.
- **Reset mid-grant.** Assert rst asynchronously while grant_idx=3'b010 → grant drops to 0 immediately, without waiting for clk. After release of rst with req=8'b1000_0100 → grant_idx=3'b010, because ptr was reset to 0.
